// File: rtl/mmio_responder_pkg.sv
// Shared CAPI MMIO types: PSL request/response structs, responder FSM states
// and odd-parity helpers.
package mmio_responder_pkg;

  localparam int unsigned IDX_W = 23;

  typedef struct packed {
    logic        valid;
    logic        read;
    logic        doubleword;
    logic        cfg;
    logic [0:23] address;
    logic        address_parity;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceInput;

  typedef struct packed {
    logic        ack;
    logic [0:63] data;
    logic        data_parity;
  } MMIOInterfaceOutput;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ACK
  } MMIO_STATE;

  function automatic logic odd_parity(input logic [63:0] v);
    return ~^v;
  endfunction

  function automatic logic odd_parity24(input logic [23:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/mmio_regfile.sv
// NUM_REGS x 64-bit MMIO register storage with per-half write enables and a
// one-cycle update strobe per register.
module mmio_regfile
  import mmio_responder_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we_hi,
  input  logic                     i_we_lo,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [63:0]              i_wdata,
  output logic [NUM_REGS*64-1:0]   o_regs,
  output logic [NUM_REGS-1:0]      o_reg_wr
);

  logic [63:0]         r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_reg_wr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_reg_wr <= '0;
    end else begin
      r_reg_wr <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (i_idx == IDX_W'(i) && (i_we_hi || i_we_lo)) begin
          if (i_we_hi) r_regs[i][63:32] <= i_wdata[63:32];
          if (i_we_lo) r_regs[i][31:0]  <= i_wdata[31:0];
          r_reg_wr[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[g*64 +: 64] = r_regs[g];
  end

  assign o_reg_wr = r_reg_wr;

endmodule

// File: rtl/mmio_responder.sv
// CAPI MMIO responder: fixed 2-cycle request/ack pipeline over a small
// register file and a read-only AFU descriptor, with inbound parity checking.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter logic [63:0] DESC0    = 64'h0000_0001_0000_8010
) (
  input  logic                   clock,
  input  logic                   reset,
  input  MMIOInterfaceInput      mmio_in,
  output MMIOInterfaceOutput     mmio_out,
  output logic [NUM_REGS*64-1:0] regs,
  output logic [NUM_REGS-1:0]    reg_wr,
  output logic                   parity_error,
  output logic                   protocol_error
);

  MMIO_STATE r_state, w_next;

  logic        r_read, r_dw, r_cfg, r_apar, r_dpar;
  logic [23:0] r_addr;
  logic [63:0] r_wdata;

  logic        r_ack, r_rpar, r_perr, r_proterr;
  logic [63:0] r_rdata;

  logic [IDX_W-1:0]       w_idx;
  logic                   w_lo_sel, w_in_range, w_dw_bad, w_perr, w_ok;
  logic                   w_we_hi, w_we_lo;
  logic [63:0]            w_wdata, w_src, w_rdata;
  logic [31:0]            w_word;
  logic [NUM_REGS*64-1:0] w_regs;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (mmio_in.valid) w_next = DECODE;
      DECODE:  w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_read  <= 1'b0;
      r_dw    <= 1'b0;
      r_cfg   <= 1'b0;
      r_apar  <= 1'b0;
      r_dpar  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && mmio_in.valid) begin
      r_read  <= mmio_in.read;
      r_dw    <= mmio_in.doubleword;
      r_cfg   <= mmio_in.cfg;
      r_apar  <= mmio_in.address_parity;
      r_dpar  <= mmio_in.data_parity;
      r_addr  <= mmio_in.address;
      r_wdata <= mmio_in.data;
    end
  end

  // Big-endian address[0:22] is the doubleword index; address[23] (LSB) picks
  // the low word, i.e. big-endian bits [32:63].
  assign w_idx      = r_addr[23:1];
  assign w_lo_sel   = r_addr[0];
  assign w_in_range = w_idx < IDX_W'(NUM_REGS);
  assign w_dw_bad   = r_dw & w_lo_sel;
  assign w_perr     = (r_apar != odd_parity24(r_addr)) |
                      (!r_read && (r_dpar != odd_parity(r_wdata)));
  assign w_ok       = w_in_range & ~w_dw_bad & ~w_perr;
  assign w_wdata    = r_dw ? r_wdata : {2{r_wdata[31:0]}};

  always_comb begin
    w_we_hi = 1'b0;
    w_we_lo = 1'b0;
    if (r_state == DECODE && !r_read && !r_cfg && w_ok) begin
      if (r_dw) begin
        w_we_hi = 1'b1;
        w_we_lo = 1'b1;
      end else if (w_lo_sel) begin
        w_we_lo = 1'b1;
      end else begin
        w_we_hi = 1'b1;
      end
    end
  end

  always_comb begin
    w_src = '0;
    if (r_cfg) begin
      if (w_idx == '0) w_src = DESC0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (w_idx == IDX_W'(i)) w_src = w_regs[i*64 +: 64];
    end
  end

  assign w_word = w_lo_sel ? w_src[31:0] : w_src[63:32];

  always_comb begin
    w_rdata = '0;
    if (w_perr)                w_rdata = '1;
    else if (w_ok && r_read)   w_rdata = r_dw ? w_src : {2{w_word}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_rpar  <= 1'b1;
    end else if (r_state == DECODE) begin
      r_ack   <= 1'b1;
      r_rdata <= w_rdata;
      r_rpar  <= odd_parity(w_rdata);
    end else begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_rpar  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perr    <= 1'b0;
      r_proterr <= 1'b0;
    end else begin
      if (r_state == DECODE && w_perr)      r_perr    <= 1'b1;
      if (r_state != IDLE && mmio_in.valid) r_proterr <= 1'b1;
    end
  end

  mmio_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_we_hi  (w_we_hi),
    .i_we_lo  (w_we_lo),
    .i_idx    (w_idx),
    .i_wdata  (w_wdata),
    .o_regs   (w_regs),
    .o_reg_wr (reg_wr)
  );

  assign regs                 = w_regs;
  assign mmio_out.ack         = r_ack;
  assign mmio_out.data        = r_rdata;
  assign mmio_out.data_parity = r_rpar;
  assign parity_error         = r_perr;
  assign protocol_error       = r_proterr;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: hand-computed expectations, immediate
// assertions at each check.
module tb_mmio_responder;
  import mmio_responder_pkg::*;

  logic               clk;
  logic               rst;
  MMIOInterfaceInput  mmio_in;
  MMIOInterfaceOutput mmio_out;
  logic [255:0]       regs;
  logic [3:0]         reg_wr;
  logic               parity_error;
  logic               protocol_error;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned acks;
  logic [63:0] exp_regs [4];

  localparam logic [63:0] DESC0 = 64'h0000_0001_0000_8010;

  mmio_responder #(
    .NUM_REGS (4),
    .DESC0    (DESC0)
  ) dut (
    .clock          (clk),
    .reset          (rst),
    .mmio_in        (mmio_in),
    .mmio_out       (mmio_out),
    .regs           (regs),
    .reg_wr         (reg_wr),
    .parity_error   (parity_error),
    .protocol_error (protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_reg%0d", tag, i), regs[i*64 +: 64], exp_regs[i]);
  endtask

  task automatic drive(input logic rd, input logic dw, input logic cf, input logic [23:0] a,
                       input logic [63:0] d, input logic fa, input logic fd);
    mmio_in.valid          = 1'b1;
    mmio_in.read           = rd;
    mmio_in.doubleword     = dw;
    mmio_in.cfg            = cf;
    mmio_in.address        = a;
    mmio_in.address_parity = (~^a) ^ fa;
    mmio_in.data           = d;
    mmio_in.data_parity    = (~^d) ^ fd;
  endtask

  // Issues one request and returns at the negedge inside the ack cycle (N+2).
  task automatic txn(input string tag, input logic rd, input logic dw, input logic cf,
                     input logic [23:0] a, input logic [63:0] d, input logic fa, input logic fd);
    @(negedge clk);
    drive(rd, dw, cf, a, d, fa, fd);
    @(negedge clk);
    mmio_in.valid = 1'b0;
    chk({tag, "_early_ack"}, 64'(mmio_out.ack), 64'd0);
    @(negedge clk);
    chk({tag, "_ack"}, 64'(mmio_out.ack), 64'd1);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_idle_ack"}, 64'(mmio_out.ack), 64'd0);
    chk({tag, "_idle_data"}, mmio_out.data, 64'd0);
    chk({tag, "_idle_par"}, 64'(mmio_out.data_parity), 64'd1);
    chk({tag, "_idle_wr"}, 64'(reg_wr), 64'd0);
  endtask

  initial begin
    mmio_in = '0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_ack", 64'(mmio_out.ack), 64'd0);
    chk("rst_data", mmio_out.data, 64'd0);
    chk("rst_par", 64'(mmio_out.data_parity), 64'd1);
    chk("rst_wr", 64'(reg_wr), 64'd0);
    chk("rst_perr", 64'(parity_error), 64'd0);
    chk("rst_proterr", 64'(protocol_error), 64'd0);
    chk_regs("rst");

    txn("dw_wr", 1'b0, 1'b1, 1'b0, 24'h000002, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    exp_regs[1] = 64'h0123_4567_89AB_CDEF;
    chk("dw_wr_strobe", 64'(reg_wr), 64'b0010);
    chk_regs("dw_wr");
    idle_chk("dw_wr");

    txn("dw_rd", 1'b1, 1'b1, 1'b0, 24'h000002, 64'd0, 1'b0, 1'b0);
    chk("dw_rd_data", mmio_out.data, 64'h0123_4567_89AB_CDEF);
    chk("dw_rd_par", 64'(mmio_out.data_parity), 64'd1);

    txn("w_wr_lo", 1'b0, 1'b0, 1'b0, 24'h000003, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
    exp_regs[1] = 64'h0123_4567_DEAD_BEEF;
    chk("w_wr_lo_strobe", 64'(reg_wr), 64'b0010);
    chk_regs("w_wr_lo");

    txn("w_rd_lo", 1'b1, 1'b0, 1'b0, 24'h000003, 64'd0, 1'b0, 1'b0);
    chk("w_rd_lo_data", mmio_out.data, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("w_rd_lo_par", 64'(mmio_out.data_parity), 64'd1);

    txn("w_rd_hi", 1'b1, 1'b0, 1'b0, 24'h000002, 64'd0, 1'b0, 1'b0);
    chk("w_rd_hi_data", mmio_out.data, 64'h0123_4567_0123_4567);
    chk("w_rd_hi_par", 64'(mmio_out.data_parity), 64'd1);

    txn("w_wr_hi", 1'b0, 1'b0, 1'b0, 24'h000000, 64'h0000_0000_CAFE_F00D, 1'b0, 1'b0);
    exp_regs[0] = 64'hCAFE_F00D_0000_0000;
    chk("w_wr_hi_strobe", 64'(reg_wr), 64'b0001);
    chk_regs("w_wr_hi");

    txn("dw_wr_last", 1'b0, 1'b1, 1'b0, 24'h000006, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 1'b0);
    exp_regs[3] = 64'hA5A5_A5A5_5A5A_5A5A;
    chk("dw_wr_last_strobe", 64'(reg_wr), 64'b1000);
    chk_regs("dw_wr_last");

    txn("dw_rd0", 1'b1, 1'b1, 1'b0, 24'h000000, 64'd0, 1'b0, 1'b0);
    chk("dw_rd0_data", mmio_out.data, 64'hCAFE_F00D_0000_0000);
    chk("dw_rd0_par", 64'(mmio_out.data_parity), 64'd1);

    txn("cfg_rd", 1'b1, 1'b1, 1'b1, 24'h000000, 64'd0, 1'b0, 1'b0);
    chk("cfg_rd_data", mmio_out.data, DESC0);
    chk("cfg_rd_par", 64'(mmio_out.data_parity), 64'd0);

    txn("cfg_wrd", 1'b1, 1'b0, 1'b1, 24'h000001, 64'd0, 1'b0, 1'b0);
    chk("cfg_wrd_data", mmio_out.data, 64'h0000_8010_0000_8010);
    chk("cfg_wrd_par", 64'(mmio_out.data_parity), 64'd1);

    txn("cfg_rd1", 1'b1, 1'b1, 1'b1, 24'h000002, 64'd0, 1'b0, 1'b0);
    chk("cfg_rd1_data", mmio_out.data, 64'd0);

    txn("cfg_wr", 1'b0, 1'b1, 1'b1, 24'h000000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    chk("cfg_wr_strobe", 64'(reg_wr), 64'd0);
    chk_regs("cfg_wr");

    txn("oor_rd", 1'b1, 1'b1, 1'b0, 24'h000008, 64'd0, 1'b0, 1'b0);
    chk("oor_rd_data", mmio_out.data, 64'd0);
    chk("oor_rd_par", 64'(mmio_out.data_parity), 64'd1);
    chk("oor_rd_perr", 64'(parity_error), 64'd0);
    chk("oor_rd_proterr", 64'(protocol_error), 64'd0);

    txn("dw_odd", 1'b1, 1'b1, 1'b0, 24'h000003, 64'd0, 1'b0, 1'b0);
    chk("dw_odd_data", mmio_out.data, 64'd0);

    txn("oor_wr", 1'b0, 1'b1, 1'b0, 24'h000008, 64'h1234_5678_1234_5678, 1'b0, 1'b0);
    chk("oor_wr_strobe", 64'(reg_wr), 64'd0);
    chk_regs("oor_wr");
    chk("oor_wr_perr", 64'(parity_error), 64'd0);

    txn("dpar_wr", 1'b0, 1'b1, 1'b0, 24'h000002, 64'h1111_1111_1111_1111, 1'b0, 1'b1);
    chk("dpar_wr_strobe", 64'(reg_wr), 64'd0);
    chk_regs("dpar_wr");
    chk("dpar_wr_perr", 64'(parity_error), 64'd1);

    txn("apar_rd", 1'b1, 1'b1, 1'b0, 24'h000002, 64'd0, 1'b1, 1'b0);
    chk("apar_rd_data", mmio_out.data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("apar_rd_par", 64'(mmio_out.data_parity), 64'd1);
    chk("apar_rd_proterr", 64'(protocol_error), 64'd0);

    // Second valid in the DECODE cycle must be dropped, never acked or written.
    acks = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 24'h000002, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    if (mmio_out.ack) acks++;
    drive(1'b0, 1'b1, 1'b0, 24'h000002, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mmio_in.valid = 1'b0;
      if (mmio_out.ack) acks++;
      if (i == 0) chk("proto_rd_data", mmio_out.data, 64'h0123_4567_DEAD_BEEF);
    end
    chk("proto_acks", 64'(acks), 64'd1);
    chk("proto_err", 64'(protocol_error), 64'd1);
    chk_regs("proto");

    txn("sticky_rd", 1'b1, 1'b1, 1'b0, 24'h000000, 64'd0, 1'b0, 1'b0);
    chk("sticky_proterr", 64'(protocol_error), 64'd1);
    chk("sticky_perr", 64'(parity_error), 64'd1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;
    chk("clr_perr", 64'(parity_error), 64'd0);
    chk("clr_proterr", 64'(protocol_error), 64'd0);
    chk_regs("clr");

    // Reset lands in the DECODE cycle of a write.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 24'h000004, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0);
    @(negedge clk);
    mmio_in.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ack", 64'(mmio_out.ack), 64'd0);
    chk("mid_rst_data", mmio_out.data, 64'd0);
    chk("mid_rst_par", 64'(mmio_out.data_parity), 64'd1);
    chk("mid_rst_wr", 64'(reg_wr), 64'd0);
    chk("mid_rst_perr", 64'(parity_error), 64'd0);
    chk("mid_rst_proterr", 64'(protocol_error), 64'd0);
    chk_regs("mid_rst");
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mmio_out.ack) acks++;
    end
    chk("mid_rst_late_acks", 64'(acks), 64'd0);
    chk_regs("mid_rst_late");

    txn("post_rst_wr", 1'b0, 1'b1, 1'b0, 24'h000004, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0);
    exp_regs[2] = 64'h5555_AAAA_5555_AAAA;
    chk("post_rst_strobe", 64'(reg_wr), 64'b0100);
    chk_regs("post_rst");
    idle_chk("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
